vcve2_imem_responder: RTL

// Responder end of the core's instruction-fetch interface (instr_req/gnt/rvalid/rdata/err).
// - Owns a word-addressed instruction RAM: grants requests, returns read data in order

---
 rtl/vcve2_pkg.sv | 21 ++
 rtl/vcve2_imem_responder_if.sv | 21 ++
 rtl/vcve2_imem_ram.sv | 23 ++
 rtl/vcve2_imem_responder.sv | 112 +++++++++++
 4 files changed

// File: rtl/vcve2_pkg.sv
// Shared types and helpers for the vcve2 instruction-memory responder.
package vcve2_pkg;

  localparam int unsigned IMEM_MAX_LATENCY = 4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] word_idx;
  } imem_rsp_slot_t;

  // Unsigned subtract: an address below base wraps high and lands out of range.
  function automatic logic imem_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] bytes);
    logic [31:0] off;
    off = addr - base;
    return {1'b0, off} < bytes;
  endfunction

endpackage

// File: rtl/vcve2_imem_responder_if.sv
// Instruction-fetch bus between the core IF stage (master) and its memory (slave).
interface vcve2_imem_responder_if;

  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;

  modport master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_rvalid, instr_rdata, instr_err
  );

  modport slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_rvalid, instr_rdata, instr_err
  );

endinterface

// File: rtl/vcve2_imem_ram.sv
// Single write port, single synchronous read port RAM with no reset, shaped for BRAM inference.
// A read and write of the same word in one cycle returns the old contents.
module vcve2_imem_ram #(
  parameter int unsigned MemWords = 1024,
  localparam int unsigned AW      = $clog2(MemWords)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MemWords];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vcve2_imem_responder.sv
// Instruction-fetch responder: grants fetches and returns RAM words in order RspLatency cycles later.
// Misaligned or out-of-range fetches still get a response, with err set and zero data.
module vcve2_imem_responder
  import vcve2_pkg::*;
#(
  parameter int unsigned MemWords   = 1024,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter int unsigned RspLatency = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  vcve2_imem_responder_if.slave bus,
  input  logic                  stall_i,
  input  logic                  ld_we_i,
  input  logic [31:0]           ld_addr_i,
  input  logic [31:0]           ld_wdata_i,
  output logic [31:0]           rsp_count_o
);

  localparam int unsigned AW       = $clog2(MemWords);
  localparam logic [32:0] MemBytes = 33'(MemWords) << 2;

  if (RspLatency < 1 || RspLatency > IMEM_MAX_LATENCY) begin : g_bad_latency
    $error("RspLatency out of range 1..%0d", IMEM_MAX_LATENCY);
  end
  if ((64'(BaseAddr) % (64'(MemWords) * 64'd4)) != 64'd0) begin : g_bad_base
    $error("BaseAddr must be aligned to the RAM size in bytes");
  end
  if (MemWords < 4 || (MemWords & (MemWords - 1)) != 0) begin : g_bad_words
    $error("MemWords must be a power of two and at least 4");
  end

  imem_rsp_slot_t acc;
  imem_rsp_slot_t pre;
  imem_rsp_slot_t fin;
  imem_rsp_slot_t pipe_q [RspLatency];
  logic           gnt;
  logic [31:0]    fetch_off;
  logic [31:0]    ld_off;
  logic           ld_ok;
  logic [31:0]    ram_rdata;

  // Load port wins over fetch so preload never races a read of the same cycle's grant.
  assign gnt           = bus.instr_req & ~stall_i & ~ld_we_i;
  assign bus.instr_gnt = gnt;
  assign fetch_off     = bus.instr_addr - BaseAddr;

  always_comb begin
    acc          = '0;
    acc.valid    = gnt;
    acc.err      = (bus.instr_addr[1:0] != 2'b00) |
                   ~imem_in_range(bus.instr_addr, BaseAddr, MemBytes);
    acc.word_idx = {2'b00, fetch_off[31:2]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RspLatency); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= acc;
      for (int i = 1; i < int'(RspLatency); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // The RAM is read from the slot about to enter the final stage, so data lands with rvalid.
  if (RspLatency == 1) begin : g_rd_acc
    assign pre = acc;
  end else begin : g_rd_pipe
    assign pre = pipe_q[RspLatency-2];
  end
  assign fin = pipe_q[RspLatency-1];

  assign ld_off = ld_addr_i - BaseAddr;
  assign ld_ok  = ld_we_i & (ld_addr_i[1:0] == 2'b00) &
                  imem_in_range(ld_addr_i, BaseAddr, MemBytes);

  vcve2_imem_ram #(.MemWords(MemWords)) u_ram (
    .clk_i (clk_i),
    .we    (ld_ok),
    .waddr (ld_off[AW+1:2]),
    .wdata (ld_wdata_i),
    .re    (pre.valid & ~pre.err),
    .raddr (pre.word_idx[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.instr_rvalid = fin.valid;
  assign bus.instr_err    = fin.valid & fin.err;
  assign bus.instr_rdata  = (fin.valid & ~fin.err) ? ram_rdata : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        rsp_count_o <= '0;
    else if (fin.valid) rsp_count_o <= rsp_count_o + 32'd1;
  end

  // Fills with ones after reset; lets the latency check ignore grants lost to a reset.
  logic [IMEM_MAX_LATENCY-1:0] warm_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) warm_q <= '0;
    else         warm_q <= {warm_q[IMEM_MAX_LATENCY-2:0], 1'b1};
  end

  a_rsp_follows_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    warm_q[RspLatency-1] |-> (fin.valid == $past(gnt, RspLatency)));
  a_idle_rdata_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !bus.instr_rvalid |-> (bus.instr_rdata == 32'h0));

  logic unused_bits;
  assign unused_bits = ^{ld_off[1:0], ld_off[31:AW+2], pre.word_idx[31:AW],
                         fin.word_idx, warm_q};

endmodule
